// File: rtl/cache_data_pkg.sv
// Shared constants and types for the cache data-array SRAM controller.
package cache_data_pkg;

  // Geometry of the 16-set x 256-bit data array.
  localparam int NUM_SETS   = 16;
  localparam int ADDR_WIDTH = 4;
  localparam int DATA_WIDTH = 256;
  localparam int NUM_WMASKS = DATA_WIDTH / 8;

  // Init counter is one bit wider than the address so its terminal value
  // can be compared without relying on wrap-around.
  localparam int CNT_WIDTH  = ADDR_WIDTH + 1;

  // INIT zero-fills the array after reset; RUN serves cache requests.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // One line request from the cache FSM.
  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [NUM_WMASKS-1:0] wmask;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

endpackage

// File: rtl/cache_data_sram_ctrl.sv
// Initiator side of the cache data-array SRAM port: zero-fills the array
// after reset, then forwards line reads and byte-masked line writes to the
// single RW port and returns read data on a valid/ready response channel.
//
// Handshake: a request transfers on a cycle where req_valid && req_ready;
// a response transfers on a cycle where resp_valid && resp_ready. Once
// raised, resp_valid and resp_rdata hold until the response transfers.
module cache_data_sram_ctrl
  import cache_data_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_WMASKS-1:0] req_wmask,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  init_done,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(NUM_SETS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 resp_valid_q, resp_valid_d;

  req_t req;
  logic resp_stall;
  logic req_accept;

  assign req = '{we: req_we, addr: req_addr, wmask: req_wmask, wdata: req_wdata};

  // A response that is valid but not being taken blocks the port.
  assign resp_stall = resp_valid_q && !resp_ready;

  // State, zero-fill counter and response-valid registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= INIT;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  // Next-state logic and SRAM/handshake outputs. Outputs are forced to
  // their idle values while rst is high so nothing is written during reset.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    req_accept   = 1'b0;
    req_ready    = 1'b0;
    init_done    = 1'b0;
    sram_csb0    = 1'b1;
    sram_web0    = 1'b1;
    sram_wmask0  = '0;
    sram_addr0   = '0;
    sram_din0    = '0;

    if (!rst) begin
      unique case (state_q)
        INIT: begin
          // One full-mask zero write per cycle, sets 0..NUM_SETS-1.
          sram_csb0    = 1'b0;
          sram_web0    = 1'b0;
          sram_wmask0  = '1;
          sram_addr0   = cnt_q[ADDR_WIDTH-1:0];
          sram_din0    = '0;
          resp_valid_d = 1'b0;
          cnt_d        = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_d = RUN;
          end
        end

        RUN: begin
          init_done  = 1'b1;
          req_ready  = !resp_stall;
          req_accept = req_valid && req_ready;
          // Deselecting the macro on a stall holds its registered address,
          // which keeps sram_dout0 (and so resp_rdata) stable.
          sram_csb0  = !req_accept;
          sram_web0  = !req.we;
          sram_addr0 = req.addr;
          sram_din0  = req.wdata;
          sram_wmask0 = req.we ? req.wmask : '0;
          // Reads respond one cycle after acceptance; writes never respond.
          resp_valid_d = (req_accept && !req.we) || resp_stall;
        end

        default: begin
          state_d = INIT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign resp_valid = resp_valid_q && !rst;
  // Read data comes straight from the macro; its registered address is
  // the one captured when the read was accepted.
  assign resp_rdata = sram_dout0;

endmodule

// File: tb/tb_cache_data_sram_ctrl.sv
// Bench for cache_data_sram_ctrl with a behavioural model of the data SRAM
// macro attached to the controller's SRAM port.
module tb_cache_data_sram_ctrl;
  import cache_data_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                  req_valid, req_ready, req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [NUM_WMASKS-1:0] req_wmask;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid, resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  init_done;
  logic                  sram_csb0, sram_web0;
  logic [NUM_WMASKS-1:0] sram_wmask0;
  logic [ADDR_WIDTH-1:0] sram_addr0;
  logic [DATA_WIDTH-1:0] sram_din0, sram_dout0;

  cache_data_sram_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wmask(req_wmask), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .init_done(init_done),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
  );

  // ---------------- SRAM macro model ----------------
  // Inputs captured only while csb0=0; the registered write commits on the
  // next posedge (and keeps re-committing while the registers hold).
  logic [DATA_WIDTH-1:0] mem [NUM_SETS];
  logic                  m_csb_r, m_web_r;
  logic [NUM_WMASKS-1:0] m_wmask_r;
  logic [ADDR_WIDTH-1:0] m_addr_r;
  logic [DATA_WIDTH-1:0] m_din_r;

  initial begin
    m_csb_r = 1'b1;
    m_web_r = 1'b1;
    m_wmask_r = '0;
    m_addr_r = '0;
    m_din_r = '0;
  end

  always @(posedge clk) begin
    if (!m_csb_r && !m_web_r) begin
      for (int b = 0; b < NUM_WMASKS; b++)
        if (m_wmask_r[b]) mem[m_addr_r][b*8 +: 8] <= m_din_r[b*8 +: 8];
    end
    if (!sram_csb0) begin
      m_csb_r   <= sram_csb0;
      m_web_r   <= sram_web0;
      m_wmask_r <= sram_wmask0;
      m_addr_r  <= sram_addr0;
      m_din_r   <= sram_din0;
    end
  end

  assign sram_dout0 = mem[m_addr_r];

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int n_resp   = 0;
  int wait_cycles = 0;
  logic rv_at_accept;
  logic [DATA_WIDTH-1:0] ref_mem [NUM_SETS];
  logic [DATA_WIDTH-1:0] exp_q[$];
  logic [DATA_WIDTH-1:0] mon_exp;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_v, input logic [NUM_WMASKS-1:0] m,
    input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] r;
    r = old_v;
    for (int b = 0; b < NUM_WMASKS; b++)
      if (m[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] rand_line();
    logic [DATA_WIDTH-1:0] r;
    for (int w = 0; w < DATA_WIDTH / 32; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  // A response transfers at the posedge after a negedge with valid&&ready
  // (inputs only change just after posedge).
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      n_checks++;
      n_resp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL resp_unexpected: got %h, no response expected", resp_rdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if (resp_rdata !== mon_exp) begin
          n_fail++;
          $display("FAIL resp_data: got %h expected %h", resp_rdata, mon_exp);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a posedge; returns just after the posedge on which the
  // request transferred, with req_valid dropped.
  task automatic issue(input logic we, input logic [ADDR_WIDTH-1:0] a,
                       input logic [NUM_WMASKS-1:0] m, input logic [DATA_WIDTH-1:0] d);
    logic accepted;
    accepted = 1'b0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wmask = m; req_wdata = d;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (req_ready) begin
        accepted = 1'b1;
        rv_at_accept = resp_valid;
        if (we) ref_mem[a] = merge_bytes(ref_mem[a], m, d);
        else exp_q.push_back(ref_mem[a]);
        break;
      end
      wait_cycles++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (!accepted) begin
      n_fail++;
      $display("FAIL req_accept_timeout: addr %0d not accepted in 50 cycles, required acceptance", a);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    @(negedge clk);
    n_checks++;
    if ({resp_valid, req_ready, init_done, sram_csb0, sram_web0} !== 5'b00011 ||
        sram_wmask0 !== '0 || sram_addr0 !== '0 || sram_din0 !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rv/rdy/done/csb/web=%b%b%b%b%b wmask=%h addr=%0d, required 00011 and zeros",
               resp_valid, req_ready, init_done, sram_csb0, sram_web0, sram_wmask0, sram_addr0);
    end
    for (int s = 0; s < NUM_SETS; s++) ref_mem[s] = '0;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Starts right after rst is released; counts the zero-fill cycles.
  task automatic test_init_fill();
    int k;
    k = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (init_done) break;
      n_checks++;
      if (sram_csb0 !== 1'b0 || sram_web0 !== 1'b0 || sram_addr0 !== ADDR_WIDTH'(k) ||
          sram_wmask0 !== '1 || sram_din0 !== '0 || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL init_drive: cycle %0d csb=%b web=%b addr=%0d rdy=%b, required csb=0 web=0 addr=%0d rdy=0 full mask zero data",
                 k, sram_csb0, sram_web0, sram_addr0, req_ready, k);
      end
      k++;
    end
    n_checks++;
    if (k != NUM_SETS) begin
      n_fail++;
      $display("FAIL init_length: %0d init cycles, required %0d", k, NUM_SETS);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_read_after_init();
    resp_ready = 1'b1;
    issue(1'b0, 4'd7, '0, '0);
    @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== '0) begin
      n_fail++;
      $display("FAIL init_read7: valid=%b data=%h, required valid=1 data 0", resp_valid, resp_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    logic [DATA_WIDTH-1:0] a5;
    a5 = {NUM_WMASKS{8'hA5}};
    issue(1'b1, 4'd3, '1, a5);
    issue(1'b0, 4'd3, '0, '0);
    n_checks++;
    if (rv_at_accept !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_latency_early: resp_valid=%b in accept cycle, required 0", rv_at_accept);
    end
    @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== a5) begin
      n_fail++;
      $display("FAIL rd_latency_data: valid=%b data=%h, required valid=1 data %h", resp_valid, resp_rdata, a5);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_single_resp: valid=%b one cycle after response, required 0", resp_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_byte_mask();
    logic [DATA_WIDTH-1:0] wd, want;
    wd = {NUM_WMASKS{8'hFF}};
    wd[7:0] = 8'h11;
    want = {{(NUM_WMASKS-1){8'hA5}}, 8'h11};
    issue(1'b1, 4'd3, 32'h0000_0001, wd);
    issue(1'b0, 4'd3, '0, '0);
    @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== want) begin
      n_fail++;
      $display("FAIL byte_mask: valid=%b data=%h, required %h", resp_valid, resp_rdata, want);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [DATA_WIDTH-1:0] l5;
    l5 = rand_line();
    issue(1'b1, 4'd5, '1, l5);
    issue(1'b1, 4'd6, '1, rand_line());
    resp_ready = 1'b0;
    issue(1'b0, 4'd5, '0, '0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd6; req_wmask = '0; req_wdata = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || sram_csb0 !== 1'b1 || resp_rdata !== l5) begin
        n_fail++;
        $display("FAIL stall_hold: cycle %0d valid=%b rdy=%b csb=%b data=%h, required 1 0 1 data %h",
                 c, resp_valid, req_ready, sram_csb0, resp_rdata, l5);
      end
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || sram_csb0 !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: rdy=%b csb=%b when resp_ready rises, required rdy=1 csb=0", req_ready, sram_csb0);
    end
    if (req_ready) exp_q.push_back(ref_mem[6]);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_next_resp: valid=%b for set 6, required 1", resp_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int r0;
    for (int s = 0; s < NUM_SETS; s++)
      issue(1'b1, ADDR_WIDTH'(s), NUM_WMASKS'($urandom), rand_line());
    resp_ready = 1'b1;
    r0 = n_resp;
    wait_cycles = 0;
    for (int s = 0; s < NUM_SETS; s++) issue(1'b0, ADDR_WIDTH'(s), '0, '0);
    @(negedge clk);
    @(posedge clk); #1;
    n_checks++;
    if (n_resp - r0 != NUM_SETS || wait_cycles != 0) begin
      n_fail++;
      $display("FAIL stream_rate: %0d responses %0d stall cycles, required %0d and 0",
               n_resp - r0, wait_cycles, NUM_SETS);
    end
  endtask

  task automatic test_reset_midflight();
    resp_ready = 1'b0;
    issue(1'b0, 4'd9, '0, '0);
    rst = 1'b1;
    exp_q.delete();
    for (int s = 0; s < NUM_SETS; s++) ref_mem[s] = '0;
    @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b0 || sram_csb0 !== 1'b1 || sram_web0 !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_during: valid=%b csb=%b web=%b, required 0 1 1", resp_valid, sram_csb0, sram_web0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b0 || init_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_drop: valid=%b init_done=%b after reset, required 0 0", resp_valid, init_done);
    end
    @(posedge clk);
    // Re-align to the first post-reset cycle boundary without losing it.
    #1;
    // The cycle sampled above was cycle 0 of INIT; count the rest.
    begin
      int k;
      k = 1;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (init_done) break;
        n_checks++;
        if (sram_csb0 !== 1'b0 || sram_web0 !== 1'b0 || sram_addr0 !== ADDR_WIDTH'(k)) begin
          n_fail++;
          $display("FAIL reinit_drive: cycle %0d csb=%b web=%b addr=%0d, required 0 0 %0d",
                   k, sram_csb0, sram_web0, sram_addr0, k);
        end
        k++;
      end
      n_checks++;
      if (k != NUM_SETS) begin
        n_fail++;
        $display("FAIL reinit_length: %0d init cycles, required %0d", k, NUM_SETS);
      end
      @(posedge clk); #1;
    end
    for (int s = 0; s < NUM_SETS; s++) issue(1'b0, ADDR_WIDTH'(s), '0, '0);
    idle(2);
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wmask = '0; req_wdata = '0;
    resp_ready = 1'b1;
    test_reset();
    test_init_fill();
    test_read_after_init();
    test_write_read();
    test_byte_mask();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cache_data_sram_ctrl.md
Name: cache_data_sram_ctrl

Overview:
Initiator side of the cache data-array SRAM port. It accepts line read and byte-masked line write requests from the cache FSM over a valid/ready handshake and drives the single RW port of the 16-set x 256-bit data SRAM macro. It returns read data on a valid/ready response channel and zero-fills the whole array after every reset. The SRAM macro sits outside this block and is instantiated by the parent or the bench.

Parameters:
NUM_SETS, 16, number of SRAM words (cache sets)
ADDR_WIDTH, 4, log2(NUM_SETS)
DATA_WIDTH, 256, line width in bits
NUM_WMASKS, 32, byte-enable count (DATA_WIDTH/8)

Ports:
clk  in  1  the single clock; the SRAM clk0 is tied to the same net
rst  in  1  synchronous, active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid && req_ready
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  set index
req_wmask  in  NUM_WMASKS  byte enables (writes only)
req_wdata  in  DATA_WIDTH  write data
resp_valid  out  1  read data valid
resp_ready  in  1  consumer accepts response
resp_rdata  out  DATA_WIDTH  read line
init_done  out  1  high once zero-fill is complete
sram_csb0  out  1  active-low chip select
sram_web0  out  1  active-low write enable
sram_wmask0  out  NUM_WMASKS  byte write mask
sram_addr0  out  ADDR_WIDTH  address
sram_din0  out  DATA_WIDTH  write data
sram_dout0  in  DATA_WIDTH  read data: the SRAM drives mem[registered addr], valid in the cycle after capture

Behaviour:
- Interface decided: one clock, clk; synchronous active-high reset, rst.
- SRAM contract: the macro captures csb0, web0, wmask0, addr0 and din0 at posedge only when csb0=0. A write commits at the following posedge. dout0 follows the registered address combinationally. While csb0=1, the registered values hold, so dout0 stays stable.
- Reset (rst=1): state=INIT, cnt=0, resp_valid=0, req_ready=0, init_done=0, sram_csb0=1, sram_web0=1. All other SRAM outputs are 0.
- INIT state: drive csb0=0, web0=0, wmask0=all ones, din0=0, addr0=cnt. cnt increments each cycle. When cnt==NUM_SETS-1, the next state is RUN. Duration is exactly NUM_SETS cycles. req_ready=0 throughout.
- RUN state: init_done=1.
  - req_ready = !(resp_valid && !resp_ready).
  - sram_csb0 = !(req_valid && req_ready).
  - sram_web0 = !req_we.
  - addr0, wmask0 and din0 pass through from the request. sram_wmask0 is forced to 0 on reads.
- Read latency is 1: a read accepted in cycle N gives resp_valid=1 in cycle N+1, with resp_rdata = sram_dout0 (combinational pass-through, no data register).
- Writes produce no response.
- Backpressure: while resp_valid && !resp_ready:
  - req_ready=0 and csb0=1, so the SRAM registered address holds and resp_rdata stays stable.
  - resp_valid holds until the response is accepted.
- Same-cycle resp handshake and new request are allowed. resp_valid(next) = read accepted this cycle.
- Read-after-write to the same set in back-to-back cycles returns the new data, because the write commits on the same edge that captures the read. No forwarding is needed.
- An idle cycle after a write re-issues the identical write inside the SRAM (its registered web0 is held). This is idempotent; no action is required.
- rst asserted mid-operation: any pending response is dropped and INIT restarts from cnt=0. The full array is zero-filled again.
- Width rules: cnt is ADDR_WIDTH+1 bits wide and its terminal value is compared; it does not wrap.

Decomposition:
- Package cache_data_pkg holds:
  - the NUM_SETS, ADDR_WIDTH, DATA_WIDTH and NUM_WMASKS constants;
  - the state enum {INIT, RUN};
  - the request struct (we, addr, wmask, wdata).
- No sub-module: the FSM and pass-through logic fit in one module.
- The bench instantiates the cache_data SRAM macro and this controller side by side.

Test Plan:
1. Release rst. -> Exactly 16 cycles with csb0=0, web0=0 and addr 0..15, then init_done=1. A read of set 7 returns 256'h0.
2. Write set 3, data 0xA5 repeated, wmask all ones. Next cycle, read set 3. -> resp_valid exactly one cycle after read acceptance, with rdata all 0xA5.
3. Write set 3 with wmask=32'h0000_0001 and data byte0=0x11, then read set 3. -> Byte0=0x11, bytes 1..31 still 0xA5.
4. Read set 5, hold resp_ready=0 for 4 cycles while req_valid=1 for set 6. -> req_ready=0, csb0=1 and resp_rdata constant throughout. Set 6 is accepted in the same cycle that resp_ready rises.
5. Streaming reads of sets 0..15 with resp_ready=1. -> One response per cycle, in order, data matching a scoreboard.
6. Assert rst for 1 cycle during a pending stalled response. -> resp_valid=0 next cycle, INIT reruns for 16 cycles, and all sets read back 0.
